// File: rtl/div_unit_pkg.sv
// Shared definitions for the sequential divider: default datapath width,
// FSM state encoding and the most-negative operand constant.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] INT_MIN = {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/div_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// trial-subtract |B| with byte-wide lookahead groups chained by a second level.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r_cur,
    input  logic [WIDTH-1:0] b_mag,
    input  logic             q_msb,
    output logic [WIDTH-1:0] r_next,
    output logic             q_bit
);

    localparam int NBLK = WIDTH / 8;

    // Shifted partial remainder needs one extra bit; the restored value
    // always stays below |B| and so fits back into WIDTH bits.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] b_inv;
    logic [WIDTH-1:0] g_bit;
    logic [WIDTH-1:0] p_bit;
    logic [WIDTH-1:0] diff;
    logic [NBLK-1:0]  blk_g;
    logic [NBLK-1:0]  blk_p;
    logic [NBLK:0]    blk_c;
    logic             diff_top;

    assign r_shift = {r_cur, q_msb};
    assign b_inv   = ~b_mag;
    assign g_bit   = r_shift[WIDTH-1:0] & b_inv;
    assign p_bit   = r_shift[WIDTH-1:0] ^ b_inv;

    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_blk
            logic [7:0] gg;
            logic [7:0] pp;
            logic [8:0] c;
            logic       go;
            logic       po;

            assign gg = g_bit[gi*8 +: 8];
            assign pp = p_bit[gi*8 +: 8];

            always_comb begin
                go = 1'b0;
                po = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    go = gg[i] | (pp[i] & go);
                    po = po & pp[i];
                end
            end

            always_comb begin
                c    = '0;
                c[0] = blk_c[gi];
                for (int i = 0; i < 8; i++) begin
                    c[i+1] = gg[i] | (pp[i] & c[i]);
                end
            end

            assign blk_g[gi]       = go;
            assign blk_p[gi]       = po;
            assign diff[gi*8 +: 8] = pp ^ c[7:0];
        end
    endgenerate

    // Second-level lookahead across byte groups; carry-in of 1 completes the negation.
    always_comb begin
        blk_c    = '0;
        blk_c[0] = 1'b1;
        for (int k = 0; k < NBLK; k++) begin
            blk_c[k+1] = blk_g[k] | (blk_p[k] & blk_c[k]);
        end
    end

    // The divisor's extended top bit is 0, inverted to 1.
    assign diff_top = r_shift[WIDTH] ^ 1'b1 ^ blk_c[NBLK];
    assign q_bit    = ~diff_top;
    assign r_next   = q_bit ? diff : r_shift[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Sequential signed divider: magnitude restoring iteration, one quotient bit
// per clock, sign fix-up and exception reporting in a final DONE cycle.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             ctrl_div,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] b_mag_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             exc_reg;
    logic             ovf_reg;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] r_next;
    logic             q_bit_next;

    // Negating INT_MIN wraps to itself, which is its correct unsigned magnitude.
    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_cur  (r_reg),
        .b_mag  (b_mag_reg),
        .q_msb  (q_reg[WIDTH-1]),
        .r_next (r_next),
        .q_bit  (q_bit_next)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            r_reg          <= '0;
            q_reg          <= '0;
            b_mag_reg      <= '0;
            neg_q_reg      <= 1'b0;
            neg_r_reg      <= 1'b0;
            exc_reg        <= 1'b0;
            ovf_reg        <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ctrl_div) begin
                        neg_q_reg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        neg_r_reg <= data_operandA[WIDTH-1];
                        q_reg     <= a_mag;
                        b_mag_reg <= b_mag;
                        r_reg     <= '0;
                        if (data_operandB == '0) begin
                            exc_reg   <= 1'b1;
                            ovf_reg   <= 1'b0;
                            state_reg <= DONE;
                        end else if (data_operandA == MIN_VAL && data_operandB == '1) begin
                            exc_reg   <= 1'b1;
                            ovf_reg   <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            exc_reg   <= 1'b0;
                            ovf_reg   <= 1'b0;
                            cnt_reg   <= CW'(WIDTH - 1);
                            busy      <= 1'b1;
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_reg   <= r_next;
                    q_reg   <= {q_reg[WIDTH-2:0], q_bit_next};
                    cnt_reg <= cnt_reg - CW'(1);
                    if (cnt_reg == '0) begin
                        busy      <= 1'b0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (exc_reg) begin
                        data_result    <= ovf_reg ? MIN_VAL : '0;
                        data_remainder <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= neg_q_reg ? -q_reg : q_reg;
                        data_remainder <= neg_r_reg ? -r_reg : r_reg;
                        data_exception <= 1'b0;
                    end
                    data_resultRDY <= 1'b1;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: queue-based reference of signed division results and
// completion times, checked every cycle, plus literal expectations.
module tb_div_unit;
    import div_unit_pkg::*;

    localparam int W = DIV_WIDTH;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic         ctrl_div = 1'b0;
    logic [W-1:0] data_operandA = '0;
    logic [W-1:0] data_operandB = '0;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    always #5 clock = ~clock;

    div_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_div       (ctrl_div),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           rdy_edge;
        bit           chk_busy;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           failures = 0;
    int           edge_cnt = 0;
    int           busy_cnt = 0;
    logic [W-1:0] held_q = '0;
    logic [W-1:0] held_r = '0;
    logic         held_e = 1'b0;

    always @(posedge clock) edge_cnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Reference: plain signed arithmetic, truncating division, remainder
    // carrying the dividend's sign; exceptions complete one edge after start.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int e0);
        exp_t   m;
        longint la;
        longint lb;
        longint tq;
        longint tr;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == '0) begin
            m.q = '0; m.r = '0; m.e = 1'b1; m.rdy_edge = e0 + 1; m.chk_busy = 1'b0;
        end else if (a == INT_MIN && lb == -1) begin
            m.q = INT_MIN; m.r = '0; m.e = 1'b1; m.rdy_edge = e0 + 1; m.chk_busy = 1'b0;
        end else begin
            tq = la / lb;
            tr = la % lb;
            m.q = tq[W-1:0]; m.r = tr[W-1:0]; m.e = 1'b0;
            m.rdy_edge = e0 + W + 1; m.chk_busy = 1'b1;
        end
        return m;
    endfunction

    // Compare process: every cycle either a completion matching the queue
    // head, or outputs holding the last completed values.
    initial begin
        exp_t m;
        forever begin
            @(posedge clock);
            #1;
            if (reset_n) begin
                if (busy) busy_cnt++;
                if (data_resultRDY) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_ready: got ready=1 expected none (edge %0d)", edge_cnt);
                    end else begin
                        m = exp_q.pop_front();
                        check("quotient", 64'(data_result), 64'(m.q));
                        check("remainder", 64'(data_remainder), 64'(m.r));
                        check("exception", 64'(data_exception), 64'(m.e));
                        check("latency_edge", 64'(edge_cnt), 64'(m.rdy_edge));
                        if (m.chk_busy) check("busy_cycles", 64'(busy_cnt), 64'(W));
                        held_q = m.q;
                        held_r = m.r;
                        held_e = m.e;
                    end
                    busy_cnt = 0;
                end else begin
                    check("hold_result", 64'(data_result), 64'(held_q));
                    check("hold_rem_exc", {31'b0, data_exception, data_remainder},
                          {31'b0, held_e, held_r});
                end
            end
        end
    end

    // Caller is positioned at a negedge; ctrl_div is held for one cycle.
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
        data_operandA = a;
        data_operandB = b;
        ctrl_div = 1'b1;
        if (accept) exp_q.push_back(model(a, b, edge_cnt + 1));
        @(negedge clock);
        ctrl_div = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
        @(negedge clock);
        drive_start(a, b, accept);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < W + 10) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout: got no ready expected one within %0d cycles", W + 10);
            exp_q.delete();
        end
    endtask

    task automatic wait_ready_negedge();
        int n = 0;
        while (!data_resultRDY && n < 2 * W) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!data_resultRDY) begin
            failures++;
            $display("FAIL ready_wait: got ready=0 expected ready=1");
        end
    endtask

    logic [W-1:0] tab_a[6] = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF};
    logic [W-1:0] tab_b[6] = '{32'd1,         32'd2,         32'hFFFF_FFFE, 32'h8000_0000, 32'd5, 32'd1};

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] prod;
        longint       lr;
        longint       lb;

        #2 reset_n = 1'b0;
        #1;
        check("reset_result", 64'(data_result), 64'd0);
        check("reset_remainder", 64'(data_remainder), 64'd0);
        check("reset_exc_rdy_busy", {61'b0, data_exception, data_resultRDY, busy}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        start(32'd100, 32'd7, 1'b1);
        wait_idle();
        check("lit_100_7_q", 64'(data_result), 64'd14);
        check("lit_100_7_r", 64'(data_remainder), 64'd2);
        check("lit_100_7_e", 64'(data_exception), 64'd0);

        start(-32'sd100, 32'd7, 1'b1);
        wait_idle();
        check("lit_m100_7_q", 64'(data_result), 64'hFFFF_FFF2);
        check("lit_m100_7_r", 64'(data_remainder), 64'hFFFF_FFFE);

        start(32'd7, 32'd100, 1'b1);
        wait_idle();
        check("lit_7_100_q", 64'(data_result), 64'd0);
        check("lit_7_100_r", 64'(data_remainder), 64'd7);

        start(32'd12345, 32'd0, 1'b1);
        wait_idle();
        check("lit_div0", {31'b0, data_exception, data_result}, {31'b0, 1'b1, 32'd0});
        check("lit_div0_r", 64'(data_remainder), 64'd0);

        start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();
        check("lit_ovf", {31'b0, data_exception, data_result}, {31'b0, 1'b1, 32'h8000_0000});

        for (int i = 0; i < 6; i++) begin
            start(tab_a[i], tab_b[i], 1'b1);
            wait_idle();
        end

        // A start pulse mid-run must be ignored; a start on the ready cycle is taken.
        start(32'd100, 32'd7, 1'b1);
        repeat (8) @(negedge clock);
        start(32'd50, 32'd5, 1'b0);
        wait_ready_negedge();
        check("lit_ignored_q", 64'(data_result), 64'd14);
        check("lit_ignored_r", 64'(data_remainder), 64'd2);
        drive_start(32'd50, 32'd5, 1'b1);
        wait_idle();
        check("lit_50_5_q", 64'(data_result), 64'd10);
        check("lit_50_5_r", 64'(data_remainder), 64'd0);

        // Asynchronous abort mid-run.
        start(32'h7FFF_FFFF, 32'd3, 1'b0);
        repeat (14) @(negedge clock);
        #2;
        reset_n = 1'b0;
        held_q = '0;
        held_r = '0;
        held_e = 1'b0;
        busy_cnt = 0;
        #1;
        check("abort_result", 64'(data_result), 64'd0);
        check("abort_rem_exc_busy", {29'b0, busy, data_exception, data_remainder}, 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        check("abort_busy_after", 64'(busy), 64'd0);

        start(32'd9, 32'd2, 1'b1);
        wait_idle();
        check("lit_9_2_q", 64'(data_result), 64'd4);
        check("lit_9_2_r", 64'(data_remainder), 64'd1);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 2) == 0) rb = W'($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 0 && $urandom_range(0, 3) == 0) rb = -rb;
            if (rb == '0) rb = 32'd3;
            if (ra == INT_MIN && rb == '1) rb = 32'd2;
            start(ra, rb, 1'b1);
            wait_idle();
            prod = data_result * rb + data_remainder;
            check("identity_qb_plus_r", 64'(prod), 64'(ra));
            lr = longint'($signed(data_remainder));
            lb = longint'($signed(rb));
            if (lr < 0) lr = -lr;
            if (lb < 0) lb = -lb;
            check("rem_below_divisor", 64'(lr < lb), 64'd1);
        end

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
